// File: rtl/add_sub_accum.sv
// Frame accumulator: adds/subtracts a stream of operands through a ripple
// adder/subtractor and hands the framed result out over valid/ready.
module add_sub_accum #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_clr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] base, b_eff, sum, sat_val;
    logic [WIDTH:0]   carry;
    logic             v;

    // Ripple chain: B is inverted for subtraction and the mode bit is the carry-in.
    always_comb begin
        base     = in_clr ? '0 : acc_q;
        b_eff    = in_data ^ {WIDTH{in_sub}};
        carry    = '0;
        sum      = '0;
        carry[0] = in_sub;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = base[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (base[i] & b_eff[i]) | (carry[i] & (base[i] ^ b_eff[i]));
        end
        v       = (base[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != base[WIDTH-1]);
        sat_val = {base[WIDTH-1], {(WIDTH-1){~base[WIDTH-1]}}};
        acc_d   = (SAT && v) ? sat_val : sum;
        cout_d  = carry[WIDTH];
        ovf_d   = (in_clr ? 1'b0 : ovf_q) | v;
        if (in_clr)
            count_d = CNT_W'(1);
        else if (&count_q)
            count_d = count_q;
        else
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        cout_q  <= cout_d;
                        ovf_q   <= ovf_d;
                        count_q <= count_d;
                        if (in_last)
                            state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Clearing here makes the next frame start from zero regardless of in_clr.
                    if (out_ready) begin
                        acc_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_add_sub_accum.sv
// Bench for add_sub_accum: wrap (SAT=0) and saturating (SAT=1) instances share
// stimulus and are compared every cycle against an integer-arithmetic model.
module tb_add_sub_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sub, in_clr, in_last, out_ready;
    logic [3:0] in_data;
    logic       o_in_ready  [2];
    logic       o_out_valid [2];
    logic [3:0] o_acc       [2];
    logic       o_cout      [2];
    logic       o_ovf       [2];
    logic [3:0] o_count     [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index = SAT value
    int m_acc [2];
    int m_cout[2];
    int m_ovf [2];
    int m_cnt;
    bit m_hold;

    always #5 clk = ~clk;

    add_sub_accum #(.WIDTH(4), .CNT_W(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o_in_ready[0]), .in_data(in_data),
        .in_sub(in_sub), .in_clr(in_clr), .in_last(in_last),
        .out_valid(o_out_valid[0]), .out_ready(out_ready),
        .out_acc(o_acc[0]), .out_cout(o_cout[0]), .out_ovf(o_ovf[0]),
        .out_count(o_count[0])
    );

    add_sub_accum #(.WIDTH(4), .CNT_W(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o_in_ready[1]), .in_data(in_data),
        .in_sub(in_sub), .in_clr(in_clr), .in_last(in_last),
        .out_valid(o_out_valid[1]), .out_ready(out_ready),
        .out_acc(o_acc[1]), .out_cout(o_cout[1]), .out_ovf(o_ovf[1]),
        .out_count(o_count[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_acc[s] = 0; m_cout[s] = 0; m_ovf[s] = 0;
        end
        m_cnt  = 0;
        m_hold = 0;
    endtask

    task automatic check_all();
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("in_ready[sat%0d]", s),  int'(o_in_ready[s]),  int'(!m_hold));
            chk($sformatf("out_valid[sat%0d]", s), int'(o_out_valid[s]), int'(m_hold));
            chk($sformatf("acc[sat%0d]", s),       int'(o_acc[s]),       m_acc[s]);
            chk($sformatf("cout[sat%0d]", s),      int'(o_cout[s]),      m_cout[s]);
            chk($sformatf("ovf[sat%0d]", s),       int'(o_ovf[s]),       m_ovf[s]);
            chk($sformatf("count[sat%0d]", s),     int'(o_count[s]),     m_cnt);
        end
    endtask

    // Advance one clock; the model applies the values present at the edge.
    task automatic step();
        bit v_i = in_valid, sub_i = in_sub, clr_i = in_clr, last_i = in_last, rdy_i = out_ready;
        int d = int'(in_data);
        @(posedge clk);
        if (!m_hold) begin
            if (v_i) begin
                for (int s = 0; s < 2; s++) begin
                    int base = clr_i ? 0 : m_acc[s];
                    int sb   = (base >= 8) ? base - 16 : base;
                    int sd   = (d >= 8) ? d - 16 : d;
                    int ts   = sub_i ? sb - sd : sb + sd;
                    bit ov   = (ts > 7) || (ts < -8);
                    m_cout[s] = sub_i ? int'(base >= d) : int'(base + d > 15);
                    m_ovf[s]  = (clr_i ? 0 : m_ovf[s]) | int'(ov);
                    if (s == 1 && ov) m_acc[s] = (ts > 7) ? 7 : 8;
                    else              m_acc[s] = (sub_i ? base - d : base + d) & 15;
                end
                m_cnt = clr_i ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
                if (last_i) m_hold = 1;
            end
        end else if (rdy_i) begin
            model_reset();
        end
        #1;
        check_all();
    endtask

    task automatic beat(input int d, input bit sub, input bit clr, input bit last);
        in_valid = 1'b1; in_data = 4'(d); in_sub = sub; in_clr = clr; in_last = last;
        step();
        in_valid = 1'b0; in_sub = 1'b0; in_clr = 1'b0; in_last = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0;
        in_clr = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst = 1'b0;
        #1 check_all();

        // Add frame with signed overflow
        beat(3, 0, 0, 0); beat(4, 0, 0, 0); beat(5, 0, 0, 1);
        chk("add_acc", int'(o_acc[0]), 12);
        chk("add_ovf", int'(o_ovf[0]), 1);
        chk("add_cnt", int'(o_count[0]), 3);
        chk("add_valid", int'(o_out_valid[0]), 1);
        take_result();

        // Subtraction with and without borrow
        beat(5, 0, 0, 0); beat(7, 1, 0, 1);
        chk("sub_acc", int'(o_acc[0]), 14);
        chk("sub_cout", int'(o_cout[0]), 0);
        chk("sub_ovf", int'(o_ovf[0]), 0);
        take_result();
        beat(7, 0, 0, 0); beat(5, 1, 0, 1);
        chk("sub2_acc", int'(o_acc[0]), 2);
        chk("sub2_cout", int'(o_cout[0]), 1);
        take_result();

        // Saturation on the SAT=1 instance
        beat(7, 0, 0, 0); beat(1, 0, 0, 1);
        chk("satp_acc", int'(o_acc[1]), 7);
        chk("satp_ovf", int'(o_ovf[1]), 1);
        chk("wrap_acc", int'(o_acc[0]), 8);
        take_result();
        beat(8, 0, 0, 0); beat(1, 1, 0, 1);
        chk("satn_acc", int'(o_acc[1]), 8);
        chk("satn_ovf", int'(o_ovf[1]), 1);

        // Backpressure: result held, new beats refused
        in_valid = 1'b1; in_data = 4'd9;
        repeat (3) step();
        chk("bp_ready", int'(o_in_ready[0]), 0);
        chk("bp_acc", int'(o_acc[1]), 8);
        in_valid = 1'b0;
        take_result();
        beat(2, 0, 0, 1);
        chk("bp_new_acc", int'(o_acc[0]), 2);
        chk("bp_new_cnt", int'(o_count[0]), 1);
        take_result();

        // Mid-frame clear discards earlier overflow
        beat(6, 0, 0, 0); beat(6, 0, 0, 0); beat(3, 0, 1, 0); beat(1, 0, 0, 1);
        chk("clr_acc", int'(o_acc[0]), 4);
        chk("clr_ovf", int'(o_ovf[0]), 0);
        chk("clr_cnt", int'(o_count[0]), 2);
        take_result();

        // Asynchronous reset mid-frame
        beat(5, 0, 0, 0); beat(5, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", int'(o_out_valid[0]), 0);
        chk("arst_acc", int'(o_acc[0]), 0);
        check_all();
        @(negedge clk) rst = 1'b0;
        #1 check_all();
        beat(1, 0, 0, 1);
        chk("arst_new_acc", int'(o_acc[0]), 1);
        chk("arst_new_cnt", int'(o_count[0]), 1);
        take_result();

        // Count saturation: 17 beats in one frame
        for (int i = 0; i < 16; i++) beat(1, 0, 0, 0);
        beat(1, 0, 0, 1);
        chk("cnt_sat", int'(o_count[0]), 15);
        take_result();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom_range(0, 15));
            in_sub    = 1'($urandom_range(0, 1));
            in_clr    = ($urandom_range(0, 7) == 0);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
